// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: stage occupancy states and the NOP encoding
// that instantiation sites use to build each stage's BUBBLE payload.
package pipe_pkg;

  typedef enum logic [1:0] {
    PS_EMPTY = 2'd0,
    PS_FULL  = 2'd1,
    PS_SKID  = 2'd2
  } pipe_state_t;

  localparam logic [5:0]  OPCODE_RTYPE = 6'h00;
  localparam logic [5:0]  FUNCT_SLL    = 6'h00;
  // sll $0,$0,0 -- the canonical all-zero R-type NOP
  localparam logic [31:0] NOP_INSTR    = {OPCODE_RTYPE, 5'd0, 5'd0, 5'd0, 5'd0, FUNCT_SLL};

endpackage

// File: rtl/pipe_skid_stage.sv
// Valid/ready pipeline register with optional skid entry.
// Define PIPE_SKID_STAGE_SKID_EN to add the skid register and PS_SKID state.
module pipe_skid_stage
  import pipe_pkg::*;
#(
  parameter int          DW     = 128,
  parameter logic [DW-1:0] BUBBLE = '0
) (
  input  logic          CLK,
  input  logic          nRST,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  input  logic          flush,
  output logic [1:0]    count
);

  pipe_state_t   state_reg, state_next;
  logic [DW-1:0] main_reg, main_next;
  logic          in_fire, out_fire;

`ifdef PIPE_SKID_STAGE_SKID_EN
  logic [DW-1:0] skid_reg, skid_next;

  // Registered-only ready: the skid entry absorbs the cycle of latency.
  assign in_ready = (state_reg != PS_SKID);
`else
  assign in_ready = out_ready || (state_reg == PS_EMPTY);
`endif

  assign out_valid = (state_reg != PS_EMPTY);
  assign out_data  = main_reg;
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;

  always_comb begin
    case (state_reg)
      PS_FULL: count = 2'd1;
      PS_SKID: count = 2'd2;
      default: count = 2'd0;
    endcase
  end

  always_comb begin
    state_next = state_reg;
    main_next  = main_reg;
`ifdef PIPE_SKID_STAGE_SKID_EN
    skid_next  = skid_reg;
`endif
    if (flush) begin
      state_next = PS_EMPTY;
      main_next  = BUBBLE;
`ifdef PIPE_SKID_STAGE_SKID_EN
      skid_next  = BUBBLE;
`endif
    end else begin
      case (state_reg)
        PS_EMPTY: begin
          if (in_fire) begin
            main_next  = in_data;
            state_next = PS_FULL;
          end
        end
        PS_FULL: begin
          if (in_fire && out_fire) begin
            main_next = in_data;
          end else if (out_fire) begin
            main_next  = BUBBLE;
            state_next = PS_EMPTY;
`ifdef PIPE_SKID_STAGE_SKID_EN
          end else if (in_fire) begin
            skid_next  = in_data;
            state_next = PS_SKID;
`endif
          end
        end
`ifdef PIPE_SKID_STAGE_SKID_EN
        PS_SKID: begin
          if (out_fire) begin
            main_next  = skid_reg;
            skid_next  = BUBBLE;
            state_next = PS_FULL;
          end
        end
`endif
        default: begin
          state_next = PS_EMPTY;
          main_next  = BUBBLE;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_reg <= PS_EMPTY;
      main_reg  <= BUBBLE;
`ifdef PIPE_SKID_STAGE_SKID_EN
      skid_reg  <= BUBBLE;
`endif
    end else begin
      state_reg <= state_next;
      main_reg  <= main_next;
`ifdef PIPE_SKID_STAGE_SKID_EN
      skid_reg  <= skid_next;
`endif
    end
  end

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Randomized bench for pipe_skid_stage against a FIFO-queue reference model.
// Honors PIPE_SKID_STAGE_SKID_EN the same way the design does (capacity 2 vs 1).
module tb_pipe_skid_stage;

  localparam int         DW     = 8;
  localparam logic [7:0] BUBBLE = 8'h00;
`ifdef PIPE_SKID_STAGE_SKID_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif

  logic       CLK = 1'b0;
  logic       nRST;
  logic       in_valid, in_ready, out_valid, out_ready, flush;
  logic [7:0] in_data, out_data;
  logic [1:0] count;

  int n_vec = 0;
  int n_err = 0;
  logic [7:0] q[$];

  always #5 CLK = ~CLK;

  pipe_skid_stage #(.DW(DW), .BUBBLE(BUBBLE)) dut (
    .CLK(CLK), .nRST(nRST),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .flush(flush), .count(count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, ".out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, ".out_data"},  32'(out_data),  32'(BUBBLE));
    chk({tag, ".in_ready"},  32'(in_ready),  32'd1);
    chk({tag, ".count"},     32'(count),     32'd0);
  endtask

  // One cycle: drive at negedge, compare against the queue, advance the model at posedge.
  task automatic step(input logic iv, input logic [7:0] id, input logic ordy, input logic fl);
    logic       e_valid, e_rdy;
    logic [7:0] e_data;
    in_valid = iv; in_data = id; out_ready = ordy; flush = fl;
    #1;
    e_valid = (q.size() > 0);
    e_data  = e_valid ? q[0] : BUBBLE;
`ifdef PIPE_SKID_STAGE_SKID_EN
    e_rdy   = (q.size() < CAP);
`else
    e_rdy   = ordy || (q.size() == 0);
`endif
    chk("out_valid", 32'(out_valid), 32'(e_valid));
    chk("out_data",  32'(out_data),  32'(e_data));
    chk("in_ready",  32'(in_ready),  32'(e_rdy));
    chk("count",     32'(count),     32'(q.size()));
    $display("vec iv=%0b id=%02h ordy=%0b fl=%0b -> ov=%0b od=%02h ir=%0b cnt=%0d",
             iv, id, ordy, fl, out_valid, out_data, in_ready, count);
    @(posedge CLK);
    if (fl) begin
      q.delete();
    end else begin
      if (e_valid && ordy) void'(q.pop_front());
      if (iv && e_rdy) q.push_back(id);
    end
    @(negedge CLK);
  endtask

  initial begin
    nRST = 1'b0; in_valid = 1'b1; in_data = 8'hFF; out_ready = 1'b0; flush = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk_reset_outputs("reset");
    nRST = 1'b1;

    // Stream with out_ready high: one-cycle latency, no gaps
    step(1'b1, 8'h01, 1'b1, 1'b0);
    step(1'b1, 8'h02, 1'b1, 1'b0);
    step(1'b1, 8'h03, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);

    // Backpressure then drain
    step(1'b1, 8'hA5, 1'b0, 1'b0);
    step(1'b1, 8'h5A, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);

    // Flush while full, with a colliding input
    step(1'b1, 8'h31, 1'b0, 1'b0);
    step(1'b1, 8'h32, 1'b0, 1'b0);
    step(1'b1, 8'h77, 1'b1, 1'b1);
    step(1'b0, 8'h00, 1'b1, 1'b0);

`ifndef PIPE_SKID_STAGE_SKID_EN
    // Without skid, in_ready tracks out_ready combinationally while holding
    step(1'b1, 8'h44, 1'b0, 1'b0);
    out_ready = 1'b1; #1;
    chk("comb_rdy_hi", 32'(in_ready), 32'd1);
    out_ready = 1'b0; #1;
    chk("comb_rdy_lo", 32'(in_ready), 32'd0);
    step(1'b1, 8'h45, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
`endif

    // Asynchronous reset pulse between edges while at capacity
    step(1'b1, 8'hC1, 1'b0, 1'b0);
    step(1'b1, 8'hC2, 1'b0, 1'b0);
    in_valid = 1'b0;
    nRST = 1'b0;
    #1;
    chk_reset_outputs("async_rst");
    q.delete();
    #1 nRST = 1'b1;
    @(negedge CLK);
    step(1'b1, 8'h10, 1'b1, 1'b0);
    step(1'b1, 8'h11, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      step(($urandom % 4) != 0, 8'($urandom), ($urandom % 3) != 0, ($urandom % 20) == 0);
      if (q.size() > CAP) begin
        chk("model_cap", 32'(q.size()), 32'(CAP));
        q.delete();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pipe_skid_stage.md
PIPE_SKID_STAGE -- requirements
Module: pipe_skid_stage

Interface
REQ-001 SHALL have parameter DW, default 128: payload width in bits (packed control plus data bundle).
REQ-002 SHALL have parameter BUBBLE, default '0: payload value presented when the stage holds no valid entry (NOP encoding).
REQ-003 SHALL have port CLK  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port nRST  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port in_valid  input  1  upstream offers in_data.
REQ-006 SHALL have port in_ready  output  1  stage accepts in_data this cycle.
REQ-007 SHALL have port in_data  input  DW  upstream payload.
REQ-008 SHALL have port out_valid  output  1  out_data is a valid entry.
REQ-009 SHALL have port out_ready  input  1  downstream consumes out_data this cycle.
REQ-010 SHALL have port out_data  output  DW  head payload.
REQ-011 SHALL have port flush  input  1  synchronous discard of all held and incoming entries.
REQ-012 SHALL have port count  output  2  number of held entries (0..2).

Function
REQ-013 SHALL transfer on input when in_valid&&in_ready, and on output when out_valid&&out_ready.
REQ-014 SHALL implement states PS_EMPTY (0 entries), PS_FULL (main register), PS_SKID (main plus skid register).
REQ-015 SHALL drive in_ready=1 in PS_EMPTY/PS_FULL and 0 in PS_SKID, from state registers only (no combinational path from out_ready).
REQ-016 SHALL drive out_valid=1 in PS_FULL/PS_SKID; out_data=main register always; count=0/1/2 per state.
REQ-017 PS_EMPTY: input transfer -> main<=in_data, PS_FULL; else stay.
REQ-018 PS_FULL: input and output -> main<=in_data, stay; input only -> skid<=in_data, PS_SKID; output only -> main<=BUBBLE, PS_EMPTY; neither -> hold.
REQ-019 PS_SKID: output -> main<=skid, skid<=BUBBLE, PS_FULL; else hold both.
REQ-020 SHALL have a latency of one cycle from an input transfer into PS_EMPTY or PS_FULL to that payload on out_data; sustained throughput SHALL be one entry per cycle with out_ready=1.
REQ-021 SHALL preserve FIFO order; no entry SHALL be dropped or duplicated except by flush.
REQ-022 flush=1 SHALL take priority: next state PS_EMPTY, main and skid <=BUBBLE, and any same-cycle input or output transfer ignored (in_data dropped; downstream must not consume).
REQ-023 SHALL hold main=BUBBLE whenever the state is PS_EMPTY.

Reset
REQ-024 On nRST=0 (asynchronously, including mid-transfer or in PS_SKID) SHALL set state PS_EMPTY, main=skid=BUBBLE, out_valid=0, out_data=BUBBLE, in_ready=1, count=0.
REQ-025 SHALL accept a transfer on the first rising CLK after nRST deasserts.

Configuration
REQ-026 Macro PIPE_SKID_STAGE_SKID_EN defined: the skid register and PS_SKID SHALL be present per REQ-014..REQ-019.
REQ-027 Macro undefined: no skid register, PS_SKID unreachable, count max 1; in_ready SHALL be combinational out_ready||!out_valid; PS_FULL input without output SHALL be impossible; all other behaviour unchanged.

Structure
REQ-028 Enum pipe_state_t {PS_EMPTY, PS_FULL, PS_SKID} SHALL live in shared package pipe_pkg, with the RTYPE/SLL NOP constants used to build BUBBLE at instantiation sites.
REQ-029 SHALL be a single module with no sub-module; ID/EX, EX/MEM and MEM/WB stages SHALL instantiate it with their own DW/BUBBLE.

Verification (DW=8, BUBBLE=8'h00, macro defined unless noted)
REQ-030 Reset: nRST=0 for 2 cycles while in_valid=1, in_data=8'hFF -> out_valid=0, out_data=8'h00, in_ready=1, count=0.
REQ-031 Stream: out_ready=1, in_data 8'h01,8'h02,8'h03 on consecutive cycles -> out_data 8'h01,8'h02,8'h03 one cycle later each, no gaps, count stays 1.
REQ-032 Backpressure: out_ready=0, send 8'hA5 then 8'h5A -> count=2, in_ready=0, out_data=8'hA5 held; out_ready=1 -> 8'hA5 then 8'h5A, then count=0, out_data=8'h00.
REQ-033 Flush: in PS_SKID with in_valid=1, in_data=8'h77, flush=1 for one cycle -> next cycle count=0, out_valid=0, out_data=8'h00, in_ready=1; 8'h77 never appears.
REQ-034 Reset mid-operation: nRST pulses low between edges in PS_SKID -> outputs reach reset values before the next edge; following stream 8'h10,8'h11 passes in order.
REQ-035 Macro undefined: out_valid=1, out_ready toggles 1->0 mid-cycle -> in_ready follows 1->0 in the same cycle; count never exceeds 1.
